cache_fill_fsm: RTL and testbench
=================================

Name: cache_fill_fsm

Overview:
- Miss handler that answers the data cache's miss indication.
- On `miss_detected` it latches the block address and issues 8 word reads to main memory.
- It streams each returned word into the cache data array with a write strobe and the matching fill address.
- On the last word it pulses `write_tag_array`, which commits the tag/valid/LRU state and clears the cache's miss latch.
- One instance sits between the I-cache and the memory arbiter, and one between the D-cache and the arbiter.

Parameters:
- ADDR_WIDTH, 16, width of byte addresses.
- WORDS_PER_BLOCK, 8, 16-bit words per 16-byte cache block.
- CNT_WIDTH, 3, log2(WORDS_PER_BLOCK); width of the issue and receive counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- miss_detected  in  1  cache reports a miss on the current access.
- miss_address  in  16  byte address of the missing access.
- fsm_busy  out  1  fill in progress; pipeline stalls while high.
- mem_read_en  out  1  read request to memory this cycle.
- memory_address  out  16  word-aligned read address.
- memory_data_valid  in  1  memory returns one word this cycle (in request order).
- memory_data  in  16  returned word.
- write_data_array  out  1  cache `data_wr` strobe.
- fill_address  out  16  cache `addr` during the fill: {block, word index, 1'b0}.
- fill_data  out  16  cache `data_in`; equals `memory_data` combinationally.
- write_tag_array  out  1  one-cycle metadata commit.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; both counters 0; block register 0. All outputs 0, except `fill_data`, which follows `memory_data`.
- States: IDLE, FILL.
- IDLE:
  - All strobes 0.
  - If `miss_detected`=1: capture `miss_address[15:4]` into the block register, clear `issue_cnt`, `issue_done`, `recv_cnt`; next state FILL.
  - `memory_data_valid` is ignored in IDLE.
- FILL issue side:
  - `fsm_busy`=1.
  - `mem_read_en`=~`issue_done`.
  - `memory_address`={block, `issue_cnt`, 1'b0}.
  - Each cycle with `mem_read_en` high, `issue_cnt` increments. When it wraps from 7 to 0, `issue_done` sets.
  - Exactly 8 requests per fill, on 8 consecutive cycles starting with the first FILL cycle.
- FILL receive side:
  - On `memory_data_valid`=1: `write_data_array`=1, `fill_address`={block, `recv_cnt`, 1'b0}, and `recv_cnt` increments.
  - Data arriving with gaps is handled; progress is driven by valid strobes, not elapsed cycles.
- Completion:
  - In the cycle `memory_data_valid`=1 and `recv_cnt`=7, `write_tag_array`=1 together with the final `write_data_array`.
  - Next state is IDLE; `fsm_busy` falls next cycle.
- Re-trigger guard: `miss_detected` is ignored for exactly one cycle after FILL exits. This lets the cache's miss latch, cleared on the same edge, settle, so a stale miss cannot restart a fill.
- `miss_detected` dropping during FILL: ignored; the fill completes.
- Valids beyond the 8th within FILL cannot occur, because memory returns only requested words. Any valid in IDLE is ignored.
- Reset mid-FILL: immediate abort to IDLE; no `write_tag_array` is issued, so the cache metadata stays unchanged.
- Nominal latency with 4-cycle memory:
  - Requests in FILL cycles 0–7; data in cycles 4–11.
  - `write_tag_array` in cycle 11; `fsm_busy` high for 12 cycles.
- Widths: the counters wrap mod 8 naturally; `fill_address[0]` and `memory_address[0]` are always 0.

Decomposition:
- Shared package cache_pkg:
  - enum fill_state_t {IDLE, FILL}.
  - Constants WORDS_PER_BLOCK=8, OFFSET_BITS=4, TAG_BITS=6, SET_BITS=6.
  - Same package is used by the cache and the arbiter.
- One sub-module, fill_word_counter:
  - 3-bit counter with increment enable, synchronous clear, and wrap flag.
  - Instantiated twice: issue side and receive side.
- State flop, block register, and guard flop live in the top module.

Test Plan:
- Reset held low then released, no miss → all strobes 0 and `fsm_busy`=0 for 20 cycles.
- `miss_address`=0x1234 with 4-cycle memory:
  - `memory_address` 0x1230, 0x1232, …, 0x123E on FILL cycles 0–7.
  - `write_data_array` with `fill_address` 0x1230…0x123E on cycles 4–11.
  - `write_tag_array` exactly once, in cycle 11; `fsm_busy` high 12 cycles.
- Memory returning valids with 2-cycle gaps → 8 writes in order; `write_tag_array` coincides with the 8th; no extra `mem_read_en` pulses.
- Spurious `memory_data_valid` in IDLE → no write strobes, state stays IDLE.
- `rst` low during FILL cycle 6 → outputs 0 immediately; no `write_tag_array`. A subsequent miss at 0xFFF0 fills 0xFFF0…0xFFFE from word 0.
- Back-to-back misses (0x0040, then `miss_detected` still high one cycle after completion, then a new miss to 0x8000):
  - No fill during the guard cycle.
  - Second fill requests 0x8000…0x800E.

Source files
------------

// File: rtl/cache_fill_fsm_pkg.sv
// Shared cache definitions: fill FSM states and block geometry.
// Used by the cache, the fill FSMs and the memory arbiter.
// Holds type and constant definitions only; it has no timing or handshake.
package cache_pkg;

    localparam int WORDS_PER_BLOCK = 8;
    localparam int OFFSET_BITS     = 4;
    localparam int TAG_BITS        = 6;
    localparam int SET_BITS        = 6;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

endpackage

// File: rtl/cache_fill_fsm_if.sv
// Miss/fill bus between a cache, its fill FSM and the memory port.
// master = fill FSM side, slave = cache + memory side.
// No storage; the signals are carried unchanged.
interface cache_fill_fsm_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic                  miss_detected;
    logic [ADDR_WIDTH-1:0] miss_address;
    logic                  fsm_busy;
    logic                  mem_read_en;
    logic [ADDR_WIDTH-1:0] memory_address;
    logic                  memory_data_valid;
    logic [DATA_WIDTH-1:0] memory_data;
    logic                  write_data_array;
    logic [ADDR_WIDTH-1:0] fill_address;
    logic [DATA_WIDTH-1:0] fill_data;
    logic                  write_tag_array;

    modport master (
        input  miss_detected,
        input  miss_address,
        input  memory_data_valid,
        input  memory_data,
        output fsm_busy,
        output mem_read_en,
        output memory_address,
        output write_data_array,
        output fill_address,
        output fill_data,
        output write_tag_array
    );

    modport slave (
        output miss_detected,
        output miss_address,
        output memory_data_valid,
        output memory_data,
        input  fsm_busy,
        input  mem_read_en,
        input  memory_address,
        input  write_data_array,
        input  fill_address,
        input  fill_data,
        input  write_tag_array
    );

endinterface

// File: rtl/cache_fill_fsm_fill_word_counter.sv
// Word index counter for a cache block fill, with a wrap flag on the last word.
// Latency: count updates on the clock edge after inc; wrap is combinational.
// Backpressure: none; the owner gates inc.
module fill_word_counter #(
    parameter int WIDTH = 3,
    parameter int LAST  = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap
);

    assign wrap = inc && (cnt == WIDTH'(LAST));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss handler: issues one read per block word, streams returns into the data array.
// Latency: reads start the cycle after a miss; tag commit coincides with the last data write.
// Backpressure: none toward memory; the pipeline stalls on fsm_busy.
module cache_fill_fsm
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH      = 16,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int CNT_WIDTH       = 3
) (
    input  logic             clk,
    input  logic             rst,
    cache_fill_fsm_if.master bus
);

    localparam int BLK_WIDTH = ADDR_WIDTH - CNT_WIDTH - 1;

    fill_state_t           state_q;
    fill_state_t           state_d;
    logic [BLK_WIDTH-1:0]  block_q;
    logic                  guard_q;
    logic                  issue_done_q;
    logic                  start;
    logic                  issue_inc;
    logic                  recv_inc;
    logic                  issue_wrap;
    logic                  recv_wrap;
    logic [CNT_WIDTH-1:0]  issue_cnt;
    logic [CNT_WIDTH-1:0]  recv_cnt;

    // Counter enables kept outside the FSM block so recv_wrap feeds it without a loop.
    assign issue_inc = (state_q == FILL) && !issue_done_q;
    assign recv_inc  = (state_q == FILL) && bus.memory_data_valid;

    fill_word_counter #(
        .WIDTH (CNT_WIDTH),
        .LAST  (WORDS_PER_BLOCK - 1)
    ) u_issue_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (start),
        .inc  (issue_inc),
        .cnt  (issue_cnt),
        .wrap (issue_wrap)
    );

    fill_word_counter #(
        .WIDTH (CNT_WIDTH),
        .LAST  (WORDS_PER_BLOCK - 1)
    ) u_recv_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (start),
        .inc  (recv_inc),
        .cnt  (recv_cnt),
        .wrap (recv_wrap)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            block_q      <= '0;
            guard_q      <= 1'b0;
            issue_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            // The cache clears its miss latch on the commit edge; skip one cycle of stale miss.
            guard_q <= bus.write_tag_array;
            if (start) begin
                block_q      <= bus.miss_address[ADDR_WIDTH-1:CNT_WIDTH+1];
                issue_done_q <= 1'b0;
            end else if (issue_wrap) begin
                issue_done_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d              = state_q;
        start                = 1'b0;
        bus.fsm_busy         = 1'b0;
        bus.mem_read_en      = 1'b0;
        bus.memory_address   = '0;
        bus.write_data_array = 1'b0;
        bus.fill_address     = '0;
        bus.write_tag_array  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.miss_detected && !guard_q) begin
                    start   = 1'b1;
                    state_d = FILL;
                end
            end
            FILL: begin
                bus.fsm_busy       = 1'b1;
                bus.mem_read_en    = !issue_done_q;
                bus.memory_address = {block_q, issue_cnt, 1'b0};
                if (bus.memory_data_valid) begin
                    bus.write_data_array = 1'b1;
                    bus.fill_address     = {block_q, recv_cnt, 1'b0};
                end
                if (recv_wrap) begin
                    bus.write_tag_array = 1'b1;
                    state_d             = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.fill_data = bus.memory_data;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: directed misses against a latency/gap memory model,
// a per-cycle reference model of the fill protocol, and literal pins per scenario.
module tb_cache_fill_fsm;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cache_fill_fsm_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

    cache_fill_fsm #(
        .ADDR_WIDTH      (16),
        .WORDS_PER_BLOCK (8),
        .CNT_WIDTH       (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // memory side
    typedef struct {
        int          due;
        logic [15:0] addr;
    } req_t;
    req_t mq[$];
    int   lat      = 4;
    int   gap      = 0;
    bit   spur     = 1'b0;
    int   last_vld = -100;

    // observation logs, cleared per scenario
    logic [15:0] req_log[$];
    logic [15:0] wr_log[$];
    int tag_total    = 0;
    int busy_cnt     = 0;
    int tag_busy_idx = -1;
    int first_wr_idx = -1;

    // reference model: one fill is a window of 8 request cycles from its start,
    // plus 8 in-order writes counted by valid strobes
    bit          m_active = 1'b0;
    bit          m_guard  = 1'b0;
    int          m_start  = 0;
    int          m_recv   = 0;
    logic [15:0] m_base   = 16'h0;
    int          rel;
    logic [15:0] e_addr;
    bit          e_busy, e_rd, e_wr, e_tag;
    bit          was_active, was_guard;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, need %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        req_log.delete();
        wr_log.delete();
        busy_cnt     = 0;
        tag_busy_idx = -1;
        first_wr_idx = -1;
    endtask

    task automatic wait_tag(input int budget, input string name);
        int t0;
        int i;
        t0 = tag_total;
        i  = 0;
        while (tag_total == t0 && i < budget) begin
            step();
            i++;
        end
        chk(name, 32'(tag_total != t0), 32'd1);
    endtask

    // memory responder: data is a function of the requested address
    initial begin
        bus.memory_data_valid = 1'b0;
        bus.memory_data       = 16'h0;
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            if (!rst) begin
                mq.delete();
                bus.memory_data_valid = 1'b0;
                bus.memory_data       = 16'h0;
            end else if (spur) begin
                bus.memory_data_valid = 1'b1;
                bus.memory_data       = 16'hDEAD;
            end else if (mq.size() > 0 && mq[0].due <= cyc && (cyc - last_vld) > gap) begin
                bus.memory_data_valid = 1'b1;
                bus.memory_data       = mq[0].addr ^ 16'h5A5A;
                last_vld              = cyc;
                void'(mq.pop_front());
            end else begin
                bus.memory_data_valid = 1'b0;
                bus.memory_data       = 16'(cyc * 7);
            end
        end
    end

    // compare process, mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            m_active = 1'b0;
            m_guard  = 1'b0;
            chk("rst_busy",  32'(bus.fsm_busy),         32'd0);
            chk("rst_rd",    32'(bus.mem_read_en),      32'd0);
            chk("rst_maddr", 32'(bus.memory_address),   32'd0);
            chk("rst_wr",    32'(bus.write_data_array), 32'd0);
            chk("rst_faddr", 32'(bus.fill_address),     32'd0);
            chk("rst_tag",   32'(bus.write_tag_array),  32'd0);
            chk("rst_fdata", 32'(bus.fill_data),        32'(bus.memory_data));
        end else begin
            rel    = cyc - m_start;
            e_busy = m_active;
            e_rd   = m_active && rel < 8;
            e_wr   = m_active && bus.memory_data_valid;
            e_tag  = e_wr && m_recv == 7;
            chk("busy",  32'(bus.fsm_busy),         32'(e_busy));
            chk("rd_en", 32'(bus.mem_read_en),      32'(e_rd));
            chk("wr",    32'(bus.write_data_array), 32'(e_wr));
            chk("tag",   32'(bus.write_tag_array),  32'(e_tag));
            chk("fdata", 32'(bus.fill_data),        32'(bus.memory_data));
            if (e_rd) begin
                e_addr = m_base + 16'(2 * rel);
                chk("maddr", 32'(bus.memory_address), 32'(e_addr));
            end
            if (e_wr) begin
                e_addr = m_base + 16'(2 * m_recv);
                chk("faddr",   32'(bus.fill_address), 32'(e_addr));
                chk("wr_data", 32'(bus.fill_data),    32'(e_addr ^ 16'h5A5A));
            end

            was_active = m_active;
            was_guard  = m_guard;
            m_guard    = 1'b0;
            if (was_active) begin
                if (bus.memory_data_valid) begin
                    m_recv++;
                    if (m_recv == 8) begin
                        m_active = 1'b0;
                        m_guard  = 1'b1;
                    end
                end
            end else if (!was_guard && bus.miss_detected) begin
                m_active = 1'b1;
                m_start  = cyc + 1;
                m_recv   = 0;
                m_base   = {bus.miss_address[15:4], 4'h0};
            end
        end

        if (bus.mem_read_en) begin
            req_log.push_back(bus.memory_address);
            mq.push_back('{due: cyc + lat, addr: bus.memory_address});
        end
        if (bus.write_data_array) begin
            if (first_wr_idx < 0) first_wr_idx = busy_cnt;
            wr_log.push_back(bus.fill_address);
        end
        if (bus.write_tag_array) begin
            tag_total++;
            tag_busy_idx = busy_cnt;
        end
        if (bus.fsm_busy) busy_cnt++;
    end

    initial begin
        int tags0;
        bus.miss_detected = 1'b0;
        bus.miss_address  = 16'h0;

        // reset then 20 idle cycles
        rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        clear_logs();
        repeat (20) step();
        chk("idle_busy_cycles", 32'(busy_cnt),       32'd0);
        chk("idle_reqs",        32'(req_log.size()), 32'd0);
        chk("idle_writes",      32'(wr_log.size()),  32'd0);
        chk("idle_tags",        32'(tag_total),      32'd0);

        // nominal fill, 4-cycle memory
        clear_logs();
        tags0 = tag_total;
        bus.miss_address  = 16'h1234;
        bus.miss_detected = 1'b1;
        step();
        bus.miss_detected = 1'b0;
        wait_tag(40, "nom_tag_timeout");
        repeat (3) step();
        chk("nom_nreq",    32'(req_log.size()), 32'd8);
        chk("nom_req0",    32'(req_log[0]),     32'h1230);
        chk("nom_req7",    32'(req_log[7]),     32'h123E);
        chk("nom_nwr",     32'(wr_log.size()),  32'd8);
        chk("nom_wr0",     32'(wr_log[0]),      32'h1230);
        chk("nom_wr7",     32'(wr_log[7]),      32'h123E);
        chk("nom_first_wr_cycle", 32'(first_wr_idx), 32'd4);
        chk("nom_tag_cycle",      32'(tag_busy_idx), 32'd11);
        chk("nom_busy_cycles",    32'(busy_cnt),     32'd12);
        chk("nom_ntag",           32'(tag_total - tags0), 32'd1);

        // returns with 2-cycle gaps: valids on fill cycles 4,7,...,25
        clear_logs();
        tags0 = tag_total;
        gap   = 2;
        bus.miss_address  = 16'h2468;
        bus.miss_detected = 1'b1;
        step();
        bus.miss_detected = 1'b0;
        wait_tag(80, "gap_tag_timeout");
        repeat (3) step();
        gap = 0;
        chk("gap_nreq",      32'(req_log.size()), 32'd8);
        chk("gap_nwr",       32'(wr_log.size()),  32'd8);
        chk("gap_wr0",       32'(wr_log[0]),      32'h2460);
        chk("gap_wr7",       32'(wr_log[7]),      32'h246E);
        chk("gap_tag_cycle", 32'(tag_busy_idx),   32'd25);
        chk("gap_busy",      32'(busy_cnt),       32'd26);
        chk("gap_ntag",      32'(tag_total - tags0), 32'd1);

        // spurious valids while idle
        clear_logs();
        spur = 1'b1;
        repeat (3) step();
        spur = 1'b0;
        repeat (3) step();
        chk("spur_writes", 32'(wr_log.size()), 32'd0);
        chk("spur_busy",   32'(busy_cnt),      32'd0);

        // reset during fill cycle 6
        clear_logs();
        tags0 = tag_total;
        bus.miss_address  = 16'h0ABC;
        bus.miss_detected = 1'b1;
        step();
        bus.miss_detected = 1'b0;
        repeat (6) step();
        rst = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        step();
        chk("abort_ntag",  32'(tag_total - tags0), 32'd0);
        chk("abort_nreq",  32'(req_log.size()),    32'd6);
        chk("abort_nwr",   32'(wr_log.size()),     32'd2);
        chk("abort_wr0",   32'(wr_log[0]),         32'h0AB0);
        chk("abort_busy",  32'(busy_cnt),          32'd6);

        clear_logs();
        tags0 = tag_total;
        bus.miss_address  = 16'hFFF0;
        bus.miss_detected = 1'b1;
        step();
        bus.miss_detected = 1'b0;
        wait_tag(40, "post_abort_tag_timeout");
        repeat (3) step();
        chk("pa_req0", 32'(req_log[0]),     32'hFFF0);
        chk("pa_nwr",  32'(wr_log.size()),  32'd8);
        chk("pa_wr0",  32'(wr_log[0]),      32'hFFF0);
        chk("pa_wr7",  32'(wr_log[7]),      32'hFFFE);
        chk("pa_ntag", 32'(tag_total - tags0), 32'd1);

        // back-to-back: miss held through completion and the guard cycle
        clear_logs();
        bus.miss_address  = 16'h0040;
        bus.miss_detected = 1'b1;
        wait_tag(40, "b2b_first_tag_timeout");
        chk("b2b_first_req0", 32'(req_log[0]), 32'h0040);
        chk("b2b_first_wr7",  32'(wr_log[7]),  32'h004E);
        clear_logs();
        step();
        bus.miss_address = 16'h8000;
        step();
        bus.miss_detected = 1'b0;
        wait_tag(40, "b2b_second_tag_timeout");
        repeat (3) step();
        chk("b2b_nreq",  32'(req_log.size()), 32'd8);
        chk("b2b_req0",  32'(req_log[0]),     32'h8000);
        chk("b2b_req7",  32'(req_log[7]),     32'h800E);
        chk("b2b_busy",  32'(busy_cnt),       32'd12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
